// File: rtl/uart_cmd_parser_pkg.sv
// Shared types for the UART command frame parser: FSM states, error codes and width helpers.
package uart_cmd_parser_pkg;

  typedef enum logic [2:0] {
    StSync,
    StOp,
    StLen,
    StPayload,
    StChk,
    StHold
  } state_e;

  typedef enum logic [1:0] {
    ErrOverrun  = 2'd0,
    ErrChecksum = 2'd1,
    ErrLength   = 2'd2,
    ErrTimeout  = 2'd3
  } err_e;

  // Width of a field that must hold 0..max_len inclusive.
  function automatic int unsigned len_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int unsigned addr_width(input int unsigned max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-strobe input, command handshake, payload read port and error status of the parser.
interface uart_cmd_parser_if
  import uart_cmd_parser_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16
) ();
  localparam int unsigned LW = len_width(MAX_LEN);
  localparam int unsigned AW = addr_width(MAX_LEN);

  logic          i_Rx_DV;
  logic [7:0]    i_Rx_Byte;
  logic          o_Cmd_Valid;
  logic          i_Cmd_Ready;
  logic [7:0]    o_Cmd_Op;
  logic [LW-1:0] o_Cmd_Len;
  logic [AW-1:0] i_Rd_Addr;
  logic [7:0]    o_Rd_Data;
  logic          o_Busy;
  logic          o_Err_Pulse;
  logic [1:0]    o_Err_Code;

  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Cmd_Ready, i_Rd_Addr,
    output o_Cmd_Valid, o_Cmd_Op, o_Cmd_Len, o_Rd_Data, o_Busy, o_Err_Pulse, o_Err_Code
  );

  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Cmd_Ready, i_Rd_Addr,
    input  o_Cmd_Valid, o_Cmd_Op, o_Cmd_Len, o_Rd_Data, o_Busy, o_Err_Pulse, o_Err_Code
  );

endinterface

// File: rtl/uart_cmd_parser_timeout.sv
// Inter-byte timeout counter: clear restarts the count, expire flags the last cycle before
// TIMEOUT_CLKS clocks have elapsed since the clear.
module uart_cmd_parser_timeout #(
  parameter int unsigned TIMEOUT_CLKS = 160
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Clr,
  input  logic i_En,
  output logic o_Expire
);
  localparam int unsigned CW = $clog2(TIMEOUT_CLKS + 1);

  logic [CW-1:0] r_cnt;

  // Loading 1 on clear makes r_cnt equal the clocks elapsed since the clearing strobe.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_cnt <= '0;
    end else if (i_Clr) begin
      r_cnt <= CW'(1);
    end else if (i_En && (r_cnt != CW'(TIMEOUT_CLKS))) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_Expire = i_En && !i_Clr && (r_cnt == CW'(TIMEOUT_CLKS - 1));

endmodule

// File: rtl/uart_cmd_parser.sv
// Frame parser behind uart_rx: SYNC|OP|LEN|PAYLOAD|CHK, validated commands handed out
// through valid/ready with the payload held in a small register buffer.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = 434,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TIMEOUT_BYTES = 4,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input logic              i_Clock,
  input logic              i_Reset,
  uart_cmd_parser_if.slave bus
);
  localparam int unsigned LW           = len_width(MAX_LEN);
  localparam int unsigned AW           = addr_width(MAX_LEN);
  localparam int unsigned TIMEOUT_CLKS = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;

  state_e        r_state, w_state_d;
  logic [7:0]    r_sum, w_sum_d;
  logic [7:0]    r_op, w_op_d;
  logic [LW-1:0] r_len, w_len_d;
  logic [AW-1:0] r_idx, w_idx_d;
  logic          r_err_pulse, w_err_pulse_d;
  err_e          r_err_code, w_err_code_d;
  logic          w_buf_we;
  logic          w_tmo_en;
  logic          w_tmo_expire;
  logic [7:0]    r_buf [MAX_LEN];

  assign w_tmo_en = r_state inside {StOp, StLen, StPayload, StChk};

  uart_cmd_parser_timeout #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Clr   (bus.i_Rx_DV),
    .i_En    (w_tmo_en),
    .o_Expire(w_tmo_expire)
  );

  always_comb begin
    w_state_d     = r_state;
    w_sum_d       = r_sum;
    w_op_d        = r_op;
    w_len_d       = r_len;
    w_idx_d       = r_idx;
    w_err_pulse_d = 1'b0;
    w_err_code_d  = r_err_code;
    w_buf_we      = 1'b0;

    unique case (r_state)
      StSync: begin
        if (bus.i_Rx_DV && (bus.i_Rx_Byte == SYNC_BYTE)) begin
          w_sum_d   = '0;
          w_state_d = StOp;
        end
      end
      StOp: begin
        if (bus.i_Rx_DV) begin
          w_op_d    = bus.i_Rx_Byte;
          w_sum_d   = bus.i_Rx_Byte;
          w_state_d = StLen;
        end
      end
      StLen: begin
        if (bus.i_Rx_DV) begin
          w_sum_d = r_sum + bus.i_Rx_Byte;
          if (32'(bus.i_Rx_Byte) > MAX_LEN) begin
            w_err_pulse_d = 1'b1;
            w_err_code_d  = ErrLength;
            w_state_d     = StSync;
          end else begin
            w_len_d   = LW'(bus.i_Rx_Byte);
            w_idx_d   = '0;
            w_state_d = (bus.i_Rx_Byte == 8'd0) ? StChk : StPayload;
          end
        end
      end
      StPayload: begin
        if (bus.i_Rx_DV) begin
          w_buf_we = 1'b1;
          w_sum_d  = r_sum + bus.i_Rx_Byte;
          w_idx_d  = r_idx + AW'(1);
          if ((LW'(r_idx) + LW'(1)) == r_len) begin
            w_state_d = StChk;
          end
        end
      end
      StChk: begin
        if (bus.i_Rx_DV) begin
          if (bus.i_Rx_Byte == r_sum) begin
            w_state_d = StHold;
          end else begin
            w_err_pulse_d = 1'b1;
            w_err_code_d  = ErrChecksum;
            w_state_d     = StSync;
          end
        end
      end
      StHold: begin
        // Bytes arriving while a command is parked are lost; the held frame stays intact.
        if (bus.i_Rx_DV) begin
          w_err_pulse_d = 1'b1;
          w_err_code_d  = ErrOverrun;
        end
        if (bus.i_Cmd_Ready) begin
          w_state_d = StSync;
        end
      end
      default: w_state_d = StSync;
    endcase

    // Expire is never raised on a DV cycle, so it cannot collide with another error.
    if (w_tmo_expire) begin
      w_err_pulse_d = 1'b1;
      w_err_code_d  = ErrTimeout;
      w_state_d     = StSync;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state     <= StSync;
      r_sum       <= '0;
      r_op        <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_err_pulse <= 1'b0;
      r_err_code  <= ErrOverrun;
    end else begin
      r_state     <= w_state_d;
      r_sum       <= w_sum_d;
      r_op        <= w_op_d;
      r_len       <= w_len_d;
      r_idx       <= w_idx_d;
      r_err_pulse <= w_err_pulse_d;
      r_err_code  <= w_err_code_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (w_buf_we && !i_Reset) begin
      r_buf[r_idx] <= bus.i_Rx_Byte;
    end
  end

  assign bus.o_Cmd_Valid = (r_state == StHold);
  assign bus.o_Busy      = (r_state != StSync);
  assign bus.o_Cmd_Op    = r_op;
  assign bus.o_Cmd_Len   = r_len;
  assign bus.o_Err_Pulse = r_err_pulse;
  assign bus.o_Err_Code  = r_err_code;
  assign bus.o_Rd_Data   = (32'(bus.i_Rd_Addr) < MAX_LEN) ? r_buf[bus.i_Rd_Addr] : 8'h00;

endmodule
